// File: rtl/requantize_pipe_pkg.sv
// rtl/requantize_pipe_pkg.sv - shared integer types and constants for the requantize path
package sys_types;

  localparam int PKG_SHIFT_W = 6;

  typedef logic signed [31:0]            int32_t;
  typedef logic signed [7:0]             int8_t;
  typedef int32_t                        q31_mult_t;
  typedef logic signed [PKG_SHIFT_W-1:0] shift_t;

  // Clamp window that leaves the int8 range untouched (no activation).
  localparam int8_t ACT_NONE_MIN = -8'sd128;
  localparam int8_t ACT_NONE_MAX = 8'sd127;

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one lane of the 3-stage requantize datapath
// S1 multiply, S2 Q31 rounding-doubling high half, S3 shift, zero point and clamp.
module requant_lane
  import sys_types::*;
#(
  parameter int SHIFT_W = PKG_SHIFT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_i,
  input  int32_t                    acc_i,
  input  q31_mult_t                 mult_i,
  input  logic signed [SHIFT_W-1:0] shift_i,
  input  int8_t                     zp_i,
  input  int8_t                     act_min_i,
  input  int8_t                     act_max_i,
  output int8_t                     data_o,
  output logic                      sat_o
);

  // S1 state
  logic signed [63:0]        prod_q;
  logic signed [63:0]        prod_d;
  logic signed [SHIFT_W-1:0] shift1_q;
  int8_t                     zp1_q, min1_q, max1_q;

  // S2 state
  int32_t                    hi_q;
  int32_t                    hi_d;
  logic                      sat2_q;
  logic signed [SHIFT_W-1:0] shift2_q;
  int8_t                     zp2_q, min2_q, max2_q;

  // S3 state
  int8_t                     data_q;
  int8_t                     data_d;
  logic                      sat_q;
  logic                      sat_d;

  assign prod_d = $signed({{32{acc_i[31]}}, acc_i}) * $signed({{32{mult_i[31]}}, mult_i});

  logic signed [63:0] hi_full;
  logic               hi_ovf;

  assign hi_full = (prod_q + 64'sd1073741824) >>> 31;
  // Only INT32_MIN * INT32_MIN can push the high half past INT32_MAX.
  assign hi_ovf  = hi_full > 64'sd2147483647;
  assign hi_d    = hi_ovf ? 32'sh7FFF_FFFF : hi_full[31:0];

  int                 s_eff;
  logic [4:0]         amt;
  logic [31:0]        mask;
  logic [31:0]        rem;
  logic [31:0]        thr;
  int32_t             r_rsh;
  logic signed [63:0] wide;
  int32_t             r;
  logic               lsat;
  logic signed [32:0] v;
  logic signed [32:0] zp33, min33, max33;

  always_comb begin
    s_eff = int'(shift2_q);
    if (s_eff < -31) s_eff = -31;
    amt   = (s_eff > 0) ? s_eff[4:0] : (5'd0 - s_eff[4:0]);

    // Round half away from zero: negative values need a strictly larger remainder.
    mask  = (32'd1 << amt) - 32'd1;
    rem   = hi_q & mask;
    thr   = {1'b0, mask[31:1]} + {31'd0, hi_q[31]};
    r_rsh = (hi_q >>> amt) + ((rem > thr) ? 32'sd1 : 32'sd0);

    wide  = $signed({{32{hi_q[31]}}, hi_q}) <<< amt;

    lsat  = 1'b0;
    if (s_eff > 0) begin
      r = r_rsh;
    end else if (wide > 64'sd2147483647) begin
      r    = 32'sh7FFF_FFFF;
      lsat = 1'b1;
    end else if (wide < 64'shFFFF_FFFF_8000_0000) begin
      r    = 32'sh8000_0000;
      lsat = 1'b1;
    end else begin
      r = wide[31:0];
    end

    zp33  = {{25{zp2_q[7]}}, zp2_q};
    min33 = {{25{min2_q[7]}}, min2_q};
    max33 = {{25{max2_q[7]}}, max2_q};
    v     = {r[31], r} + zp33;
    sat_d = sat2_q | lsat;

    // Floor first, ceiling last, so an inverted window resolves to act_max.
    if (v < min33) begin
      v     = min33;
      sat_d = 1'b1;
    end
    if (v > max33) begin
      v     = max33;
      sat_d = 1'b1;
    end
    data_d = v[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q   <= '0;
      shift1_q <= '0;
      zp1_q    <= '0;
      min1_q   <= '0;
      max1_q   <= '0;
      hi_q     <= '0;
      sat2_q   <= 1'b0;
      shift2_q <= '0;
      zp2_q    <= '0;
      min2_q   <= '0;
      max2_q   <= '0;
      data_q   <= '0;
      sat_q    <= 1'b0;
    end else if (en_i) begin
      prod_q   <= prod_d;
      shift1_q <= shift_i;
      zp1_q    <= zp_i;
      min1_q   <= act_min_i;
      max1_q   <= act_max_i;
      hi_q     <= hi_d;
      sat2_q   <= hi_ovf;
      shift2_q <= shift1_q;
      zp2_q    <= zp1_q;
      min2_q   <= min1_q;
      max2_q   <= max1_q;
      data_q   <= data_d;
      sat_q    <= sat_d;
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/requantize_pipe.sv
// rtl/requantize_pipe.sv - multi-lane int32 to int8 requantize and activation clamp pipeline
// Owns the valid chain and handshake; lanes only see the shared advance enable.
module requantize_pipe
  import sys_types::*;
#(
  parameter int LANES   = 4,
  parameter int SHIFT_W = PKG_SHIFT_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES-1:0][31:0]          in_acc,
  input  logic [LANES-1:0][31:0]          in_mult,
  input  logic [LANES-1:0][SHIFT_W-1:0]   in_shift,
  input  int8_t                           in_zp,
  input  int8_t                           in_act_min,
  input  int8_t                           in_act_max,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES-1:0][7:0]           out_data,
  output logic [LANES-1:0]                out_sat
);

  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_valid_d, s2_valid_d, s3_valid_d;
  logic adv;

  // Bubbles move with the pipe rather than being squeezed out.
  assign adv        = !s3_valid_q || out_ready;
  assign in_ready   = adv;
  assign out_valid  = s3_valid_q;
  assign s1_valid_d = in_valid;
  assign s2_valid_d = s1_valid_q;
  assign s3_valid_d = s2_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en_i      (adv),
      .acc_i     (in_acc[g]),
      .mult_i    (in_mult[g]),
      .shift_i   (in_shift[g]),
      .zp_i      (in_zp),
      .act_min_i (in_act_min),
      .act_max_i (in_act_max),
      .data_o    (out_data[g]),
      .sat_o     (out_sat[g])
    );
  end

endmodule

// File: tb/tb_requantize_pipe.sv
// tb/tb_requantize_pipe.sv - scoreboard bench for requantize_pipe against an arithmetic model
module tb_requantize_pipe;

  localparam int LANES = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0][31:0] in_acc;
  logic [LANES-1:0][31:0] in_mult;
  logic [LANES-1:0][5:0]  in_shift;
  logic [7:0]            in_zp, in_act_min, in_act_max;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0][7:0] out_data;
  logic [LANES-1:0]      out_sat;

  requantize_pipe #(.LANES(LANES), .SHIFT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_acc     (in_acc),
    .in_mult    (in_mult),
    .in_shift   (in_shift),
    .in_zp      (in_zp),
    .in_act_min (in_act_min),
    .in_act_max (in_act_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0][7:0] data;
    logic [LANES-1:0]      sat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rdy_random = 0;

  int b_acc[LANES];
  int b_mult[LANES];
  int b_sh[LANES];
  int b_zp, b_mn, b_mx;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  // Reference: exact rational arithmetic on 64-bit integers, result {sat, int8}.
  function automatic logic [8:0] model(int acc, int mult, int shift, int zp, int mn, int mx);
    longint prod, hi, r, d, v;
    int     s;
    bit     sat;
    sat  = 0;
    prod = longint'(acc) * longint'(mult);
    hi   = (prod + 64'sd1073741824) >>> 31;
    if (hi > 64'sd2147483647) begin
      hi  = 64'sd2147483647;
      sat = 1;
    end
    s = (shift < -31) ? -31 : shift;
    if (s > 0) begin
      d = longint'(1) << s;
      if (hi >= 0) r = (hi + d / 2) / d;
      else         r = -((-hi + d / 2) / d);
    end else begin
      r = hi * (longint'(1) << (-s));
      if (r > 64'sd2147483647) begin
        r = 64'sd2147483647; sat = 1;
      end else if (r < -64'sd2147483648) begin
        r = -64'sd2147483648; sat = 1;
      end
    end
    v = r + zp;
    if (v < mn) begin v = mn; sat = 1; end
    if (v > mx) begin v = mx; sat = 1; end
    return {sat, v[7:0]};
  endfunction

  task automatic send();
    exp_t       e;
    logic [8:0] m;
    int         waitc;
    bit         ok;
    for (int l = 0; l < LANES; l++) begin
      in_acc[l]   = b_acc[l];
      in_mult[l]  = b_mult[l];
      in_shift[l] = b_sh[l][5:0];
      m           = model(b_acc[l], b_mult[l], b_sh[l], b_zp, b_mn, b_mx);
      e.data[l]   = m[7:0];
      e.sat[l]    = m[8];
    end
    in_zp      = b_zp[7:0];
    in_act_min = b_mn[7:0];
    in_act_max = b_mx[7:0];
    in_valid   = 1'b1;
    waitc = 0;
    ok    = 0;
    while (!ok) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
      end else begin
        waitc++;
        if (waitc > 60) begin
          chk("accept_timeout", 64'(waitc), 64'd0);
          break;
        end
        @(posedge clk); #1;
      end
    end
    if (ok) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic set_all(input int acc, input int mult, input int sh);
    for (int l = 0; l < LANES; l++) begin
      b_acc[l] = acc; b_mult[l] = mult; b_sh[l] = sh;
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall holds and ready.
  bit                    stall_prev = 0;
  logic [LANES-1:0][7:0] data_prev;
  logic [LANES-1:0]      sat_prev;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(data_prev));
        chk("hold_sat", 64'(out_sat), 64'(sat_prev));
      end
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_data), 64'd0);
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_sat", 64'(out_sat), 64'(e.sat));
        end
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      sat_prev   = out_sat;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int k;
    int t0, t1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_acc = '0; in_mult = '0; in_shift = '0;
    in_zp = '0; in_act_min = '0; in_act_max = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Rounding lanes and latency
    b_acc  = '{100, -3, 3, 10};
    b_mult = '{32'h4000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h4000_0000};
    b_sh   = '{1, 1, 1, -2};
    b_zp = 0; b_mn = -128; b_mx = 127;
    send();
    k = 0;
    while (k < 10) begin
      @(negedge clk); k++;
      if (out_valid) break;
    end
    chk("latency", 64'(k), 64'd3);
    repeat (2) @(posedge clk); #1;

    // Zero point, clamp window, saturation paths, inverted window
    set_all(100, 32'h4000_0000, 1);
    b_zp = -128; b_mn = -128; b_mx = 127;  send();
    b_mx = -110;                            send();
    b_acc  = '{32'h8000_0000, 32'h4000_0000, 100, -5};
    b_mult = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF};
    b_sh   = '{0, -3, -32, 2};
    b_zp = -128; b_mn = -128; b_mx = 127;  send();
    b_zp = 0;                               send();
    b_acc  = '{0, 1000, -1000, 32'h8000_0000};
    b_zp = 3; b_mn = 10; b_mx = 5;          send();
    repeat (5) @(posedge clk); #1;

    // Backpressure: 8 back-to-back beats, out_ready low for cycles 4..7
    b_zp = 0; b_mn = -128; b_mx = 127;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          set_all(i, 32'h7FFF_FFFF, 0);
          send();
          in_valid = 1'b1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset mid-flight: both beats must vanish
    set_all(50, 32'h4000_0000, 0);
    send();
    send();
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    repeat (8) @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rdy_random = 1;
    for (int n = 0; n < 250; n++) begin
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 1) != 0) b_acc[l] = int'($urandom);
        else                           b_acc[l] = int'($urandom_range(0, 4000)) - 2000;
        b_mult[l] = int'($urandom);
        b_sh[l]   = int'($urandom_range(0, 63)) - 32;
      end
      b_zp = int'($urandom_range(0, 255)) - 128;
      t0   = int'($urandom_range(0, 255)) - 128;
      t1   = int'($urandom_range(0, 255)) - 128;
      if (t0 > t1 && $urandom_range(0, 7) != 0) begin
        b_mn = t1; b_mx = t0;
      end else begin
        b_mn = t0; b_mx = t1;
      end
      send();
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end

    rdy_random = 0;
    out_ready  = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("final_drain", 64'(q.size()), 64'd0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/requantize_pipe.md
Name: requantize_pipe

Overview:
- Multi-lane, 3-stage pipelined requantize + activation clamp unit for the systolic array output path.
- Converts int32 accumulator + bias values to int8 using TFLite-style fixed-point scaling, with per-lane multiplier/shift (per-channel quantization).
- Adds a runtime zero point and clamps to a runtime [act_min, act_max] window, covering none/ReLU/ReLU6.
- Valid/ready handshake with full backpressure. Sits between the accumulator drain and the output activation buffer.

Parameters:
LANES, 4, number of parallel channels processed per beat
SHIFT_W, 6, width of signed per-lane shift field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat this cycle
in_acc  in  LANES x 32  signed accumulators (int32_t)
in_mult  in  LANES x 32  signed Q31 multipliers (int32_t)
in_shift  in  LANES x SHIFT_W  signed shift; >0 right, <=0 left
in_zp  in  8  signed output zero point (int8_t), shared by the beat
in_act_min  in  8  signed clamp floor
in_act_max  in  8  signed clamp ceiling
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES x 8  int8 results
out_sat  out  LANES  1 = lane value was clamped or saturated

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset state: all stage valids = 0; out_valid = 0; out_data = 0; out_sat = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded and no partial output is produced.
- Pipeline: 3 stages S1/S2/S3, all sharing one enable, `adv = !s3_valid || out_ready`.
  - in_ready = adv.
  - A beat is accepted on `in_valid && in_ready`.
  - Latency is 3 cycles from accept to out_valid when unstalled. Throughput is 1 beat/cycle.
  - Bubbles advance with adv and are not compacted.
  - While stalled (`s3_valid && !out_ready`), every stage register, out_data and out_sat hold.
  - out_valid = s3_valid. There is no combinational path from in_* to out_*.
- S1, per lane:
  - prod = in_acc * in_mult, full 64-bit signed.
  - Register prod, shift, zp, act_min and act_max.
- S2, per lane:
  - hi = (prod + 2^30) >>> 31.
  - Saturate hi to int32. The only overflow case is acc = mult = INT32_MIN, which gives hi = 0x7FFFFFFF and sets sat.
- S3, per lane:
  - Shift clamping: shift < -31 is treated as -31. shift > 31 is not representable.
  - shift s > 0, rounding right shift (round half away from zero):
    - mask = 2^s - 1
    - rem = hi & mask
    - thr = (mask >> 1) + (hi < 0)
    - r = (hi >>> s) + (rem > thr)
  - shift s <= 0: r = hi << -s, saturated to int32. Saturation sets sat.
  - v = r + zp, computed at 33 bits.
  - Clamp: if v < act_min then v = act_min and sat = 1. Then if v > act_max then v = act_max and sat = 1.
  - If act_min > act_max, the result is act_max.
  - out_data = v[7:0].
- Config capture: in_zp and in_act_* are sampled with each beat, so config may change beat-to-beat.

Decomposition:
- Shared package sys_types: int32_t, int8_t, q31_mult_t (int32 alias), and a shift_t typedef of width SHIFT_W.
- Add localparams ACT_NONE_MIN/MAX = -128/127 to the package for callers.
- Sub-module requant_lane: one lane's S1–S3 datapath, taking an enable input.
  - Replicated LANES times by generate.
  - The top owns the valid chain and handshake.

Test Plan:
- Rounding: LANES=4, acc={100,-3,3,10}, mult={2^30,0x7FFFFFFF,0x7FFFFFFF,2^30}, shift={1,1,1,-2}, zp=0, act=[-128,127] -> out={25,-2,2,20}, sat=0 on all lanes, out_valid 3 cycles after accept.
- Zero point and clamp: acc=100, mult=2^30, shift=1, zp=-128 -> -103. Same with act=[-128,-110] -> -110, sat=1.
- Saturation: acc=INT32_MIN, mult=INT32_MIN, shift=0, zp=-128 -> out=127, sat=1. acc=2^30, mult=0x7FFFFFFF, shift=-3 -> left saturation, out=127, sat=1.
- Backpressure: stream 8 back-to-back beats with acc=beat index, mult=0x7FFFFFFF, shift=0, zp=0; drop out_ready for cycles 4–7 -> in_ready=0 while stalled, out_data holds, all 8 results {0..7} delivered in order, no duplicates or losses.
- Reset mid-flight: accept 2 beats, assert reset for 1 cycle -> out_valid=0 next cycle; neither beat ever appears; in_ready=1.
- Inverted window: act_min=10, act_max=5, any input -> out=5, sat=1.
